// File: rtl/quic_family_gen_pkg.sv
// Shared definitions for the QUIC Golomb family table generator.
//   fg_state_t : generator FSM state encoding
//   DEF_LIMIT  : default codeword length limit used by the decoder
//   bppmask    : 2^n - 1 computed in 33 bits so that n = 32 is exact
//   ceil_log2  : ceil(log2(x)) for x >= 1, with ceil_log2(1) = 0
package quic_family_gen_pkg;

    typedef enum logic [1:0] {
        FG_IDLE  = 2'd0,
        FG_GEN   = 2'd1,
        FG_READY = 2'd2
    } fg_state_t;

    localparam logic [5:0] DEF_LIMIT = 6'd26;

    function automatic logic [32:0] bppmask(input logic [5:0] n);
        return (33'd1 << n) - 33'd1;
    endfunction

    // Bit count of (x - 1), i.e. the index of its highest set bit plus one.
    function automatic logic [4:0] ceil_log2(input logic [16:0] x);
        logic [16:0] v;
        logic [4:0]  r;
        v = x - 17'd1;
        r = '0;
        for (int i = 0; i < 17; i++) begin
            if (v[i]) r = 5'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/quic_family_gen_entry.sv
// quic_family_entry: combinational evaluation of one QUIC family table entry.
//   bpc_i          : bits per channel (1..16)
//   limit_i        : max codeword length
//   l_i            : code index being evaluated
//   ngr_o          : nGRcodewords[l]
//   cwlen_o        : notGRcwlen[l]
//   prefixmask_o   : notGRprefixmask[l]
//   suffixlen_o    : notGRsuffixlen[l]
// Indices at or beyond bpc produce all-zero fields.
module quic_family_entry
    import quic_family_gen_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [4:0]       bpc_i,
    input  logic [5:0]       limit_i,
    input  logic [IDX_W-1:0] l_i,
    output logic [31:0]      ngr_o,
    output logic [31:0]      cwlen_o,
    output logic [31:0]      prefixmask_o,
    output logic [31:0]      suffixlen_o
);

    logic [5:0]  l_ext;
    logic [5:0]  bpc_ext;
    logic [5:0]  span;
    logic [5:0]  apl;
    logic [32:0] cap;
    logic [16:0] acw;
    logic [4:0]  suffix;
    logic        active;

    always_comb begin
        l_ext        = 6'(l_i);
        bpc_ext      = {1'b0, bpc_i};
        active       = (l_ext < bpc_ext);
        span         = limit_i - bpc_ext;
        cap          = bppmask(bpc_ext - l_ext);
        apl          = ({27'd0, span} < cap) ? span : cap[5:0];
        acw          = '0;
        suffix       = '0;
        ngr_o        = '0;
        cwlen_o      = '0;
        prefixmask_o = '0;
        suffixlen_o  = '0;
        if (active) begin
            ngr_o        = 32'(apl) << l_ext;
            // 2^bpc needs 17 bits when bpc = 16; nGR is always below 2^bpc.
            acw          = (17'd1 << bpc_i) - 17'(ngr_o);
            suffix       = ceil_log2(acw);
            cwlen_o      = 32'(apl) + 32'(suffix);
            prefixmask_o = 32'(bppmask(6'd32 - apl));
            suffixlen_o  = 32'(suffix);
        end
    end

endmodule

// File: rtl/quic_family_gen.sv
// quic_family_gen: sequential generator of the QUIC Golomb family tables,
// one entry per cycle, for a runtime bpc and codeword length limit.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : latch cfg_bpc/cfg_limit and regenerate tables
//   clear             : synchronous clear of tables and flags (wins over start)
//   cfg_bpc/cfg_limit : configuration, checked for legality at start
//   busy              : generation in progress
//   done              : one-cycle pulse after the last entry is written
//   tbl_valid         : tables match the last accepted configuration
//   cfg_err           : one-cycle pulse when a start is rejected
//   rd_idx / rd_*     : combinational table read port
//
// state    | meaning
// FG_IDLE  | no tables generated since reset/clear, waiting for start
// FG_GEN   | writing entry l_q each cycle, l_q = 0..BPC_MAX-1
// FG_READY | tables valid, a new start regenerates them
module quic_family_gen
    import quic_family_gen_pkg::*;
#(
    parameter int BPC_MAX = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [4:0]       cfg_bpc,
    input  logic [5:0]       cfg_limit,
    output logic             busy,
    output logic             done,
    output logic             tbl_valid,
    output logic             cfg_err,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_ngr_codewords,
    output logic [31:0]      rd_cwlen,
    output logic [31:0]      rd_prefixmask,
    output logic [31:0]      rd_suffixlen
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BPC_MAX - 1);
    localparam logic [IDX_W:0]   DEPTH     = (IDX_W + 1)'(BPC_MAX);
    localparam logic [5:0]       BPC_MAX_W = 6'(BPC_MAX);

    fg_state_t        state_q;
    logic [IDX_W-1:0] l_q;
    logic [4:0]       bpc_q;
    logic [5:0]       limit_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             err_q;

    logic [31:0] ngr_q   [BPC_MAX];
    logic [31:0] cwlen_q [BPC_MAX];
    logic [31:0] pmask_q [BPC_MAX];
    logic [31:0] sfx_q   [BPC_MAX];

    logic [31:0] ngr_d;
    logic [31:0] cwlen_d;
    logic [31:0] pmask_d;
    logic [31:0] sfx_d;
    logic        cfg_ok;
    logic        rd_hit;

    quic_family_entry #(.IDX_W(IDX_W)) u_entry (
        .bpc_i        (bpc_q),
        .limit_i      (limit_q),
        .l_i          (l_q),
        .ngr_o        (ngr_d),
        .cwlen_o      (cwlen_d),
        .prefixmask_o (pmask_d),
        .suffixlen_o  (sfx_d)
    );

    // Legal configs keep apl within 1..31, which the entry math relies on.
    assign cfg_ok = (cfg_bpc != 5'd0) && ({1'b0, cfg_bpc} <= BPC_MAX_W) &&
                    (cfg_limit > {1'b0, cfg_bpc}) && (cfg_limit <= 6'd32);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FG_IDLE;
            l_q     <= '0;
            bpc_q   <= '0;
            limit_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < BPC_MAX; i++) begin
                ngr_q[i]   <= '0;
                cwlen_q[i] <= '0;
                pmask_q[i] <= '0;
                sfx_q[i]   <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (clear) begin
                state_q <= FG_IDLE;
                l_q     <= '0;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                for (int i = 0; i < BPC_MAX; i++) begin
                    ngr_q[i]   <= '0;
                    cwlen_q[i] <= '0;
                    pmask_q[i] <= '0;
                    sfx_q[i]   <= '0;
                end
            end else begin
                case (state_q)
                    FG_IDLE, FG_READY: begin
                        if (start) begin
                            if (cfg_ok) begin
                                bpc_q   <= cfg_bpc;
                                limit_q <= cfg_limit;
                                l_q     <= '0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= FG_GEN;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    FG_GEN: begin
                        ngr_q[l_q]   <= ngr_d;
                        cwlen_q[l_q] <= cwlen_d;
                        pmask_q[l_q] <= pmask_d;
                        sfx_q[l_q]   <= sfx_d;
                        if (l_q == LAST_IDX) begin
                            state_q <= FG_READY;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            l_q <= l_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= FG_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tbl_valid = valid_q;
    assign cfg_err   = err_q;

    assign rd_hit           = ({1'b0, rd_idx} < DEPTH);
    assign rd_ngr_codewords = rd_hit ? ngr_q[rd_idx]   : '0;
    assign rd_cwlen         = rd_hit ? cwlen_q[rd_idx] : '0;
    assign rd_prefixmask    = rd_hit ? pmask_q[rd_idx] : '0;
    assign rd_suffixlen     = rd_hit ? sfx_q[rd_idx]   : '0;

endmodule

// File: tb/tb_quic_family_gen.sv
module tb_quic_family_gen;
    import quic_family_gen_pkg::*;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_SNAP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  cfg_bpc = '0;
    logic [5:0]  cfg_limit = '0;
    logic [3:0]  rd_idx = '0;
    logic        busy, done, tbl_valid, cfg_err;
    logic [31:0] rd_ngr_codewords, rd_cwlen, rd_prefixmask, rd_suffixlen;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   snap_cnt = 0;
    int   snap_seen = 0;
    logic mon_busy = 1'b0;

    typedef struct {
        int                kind;
        int                start_cyc;
        logic              valid;
        logic [15:0]       chk;
        logic [15:0][31:0] ngr;
        logic [15:0][31:0] cw;
        logic [15:0][31:0] pm;
        logic [15:0][31:0] sf;
    } exp_t;

    exp_t sbq[$];

    quic_family_gen #(.BPC_MAX(16), .IDX_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .clear            (clear),
        .cfg_bpc          (cfg_bpc),
        .cfg_limit        (cfg_limit),
        .busy             (busy),
        .done             (done),
        .tbl_valid        (tbl_valid),
        .cfg_err          (cfg_err),
        .rd_idx           (rd_idx),
        .rd_ngr_codewords (rd_ngr_codewords),
        .rd_cwlen         (rd_cwlen),
        .rd_prefixmask    (rd_prefixmask),
        .rd_suffixlen     (rd_suffixlen)
    );

    initial forever #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s idx=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    endtask

    // Hand-computed tables: sel 8 -> bpc=8/limit=26, 5 -> bpc=5/limit=26,
    // 16 -> bpc=16/limit=26 (entries 0, 14, 15 only), 0 -> all zero.
    function automatic exp_t mk_exp(input int kind, input int sc, input logic v, input int sel);
        exp_t e;
        e.kind = kind; e.start_cyc = sc; e.valid = v; e.chk = 16'hffff;
        e.ngr = '0; e.cw = '0; e.pm = '0; e.sf = '0;
        if (sel == 8) begin
            e.ngr[7:0] = {32'h80, 32'hc0, 32'he0, 32'hf0, 32'h90, 32'h48, 32'h24, 32'h12};
            e.cw[7:0]  = {32'h08, 32'h09, 32'h0c, 32'h13, 32'h19, 32'h1a, 32'h1a, 32'h1a};
            e.pm[7:0]  = {32'h7fffffff, 32'h1fffffff, 32'h1ffffff, 32'h1ffff,
                          32'h3fff, 32'h3fff, 32'h3fff, 32'h3fff};
            e.sf[7:0]  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd7, 32'd8, 32'd8, 32'd8};
        end else if (sel == 5) begin
            e.ngr[4:0] = {32'h10, 32'h18, 32'h1c, 32'h1e, 32'h15};
            e.cw[4:0]  = {32'h05, 32'h06, 32'h09, 32'h10, 32'h19};
            e.pm[4:0]  = {32'h7fffffff, 32'h1fffffff, 32'h1ffffff, 32'h1ffff, 32'h7ff};
            e.sf[4:0]  = {32'd4, 32'd3, 32'd2, 32'd1, 32'd4};
        end else if (sel == 16) begin
            e.chk = 16'hc001;
            e.ngr[0] = 32'ha;    e.cw[0] = 32'h1a;  e.pm[0] = 32'h3fffff;   e.sf[0] = 32'h10;
            e.ngr[14] = 32'hc000; e.cw[14] = 32'h11; e.pm[14] = 32'h1fffffff; e.sf[14] = 32'he;
            e.ngr[15] = 32'h8000; e.cw[15] = 32'h10; e.pm[15] = 32'h7fffffff; e.sf[15] = 32'hf;
        end
        return e;
    endfunction

    task automatic handle(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL unexpected_event kind=%0d actual=present required=none", kind);
            return;
        end
        e = sbq.pop_front();
        mon_busy = 1'b1;
        chk("event_kind", -1, 32'(kind), 32'(e.kind));
        chk("busy", -1, {31'd0, busy}, 32'd0);
        chk("tbl_valid", -1, {31'd0, tbl_valid}, {31'd0, e.valid});
        if (kind == K_DONE) chk("done_latency", -1, 32'(cyc - e.start_cyc), 32'd17);
        for (int i = 0; i < 16; i++) begin
            if (e.chk[i]) begin
                rd_idx = 4'(i);
                #1;
                chk("ngr", i, rd_ngr_codewords, e.ngr[i]);
                chk("cwlen", i, rd_cwlen, e.cw[i]);
                chk("prefixmask", i, rd_prefixmask, e.pm[i]);
                chk("suffixlen", i, rd_suffixlen, e.sf[i]);
            end
        end
        mon_busy = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents done, cfg_err,
    // or a snapshot is requested by the stimulus.
    initial forever begin
        @(negedge clk);
        if (done === 1'b1) handle(K_DONE);
        if (cfg_err === 1'b1) handle(K_ERR);
        if (snap_cnt != snap_seen) begin
            snap_seen++;
            handle(K_SNAP);
        end
    end

    task automatic snap(input logic v, input int sel);
        sbq.push_back(mk_exp(K_SNAP, 0, v, sel));
        snap_cnt++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sbq.size() == 0 && !mon_busy) passed++;
        else begin
            $display("FAIL drain_timeout actual=%0d_pending required=0_pending", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] lim, input int sel);
        @(negedge clk);
        cfg_bpc = b; cfg_limit = lim; start = 1'b1;
        if (sel >= 0) sbq.push_back(mk_exp(K_DONE, cyc, 1'b1, sel));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic bad_start(input logic [4:0] b, input logic [5:0] lim);
        @(negedge clk);
        cfg_bpc = b; cfg_limit = lim; start = 1'b1;
        sbq.push_back(mk_exp(K_ERR, 0, 1'b1, 8));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        snap(1'b0, 0);
        drain(5);
        @(negedge clk); reset = 1'b0;

        do_start(5'd8, DEF_LIMIT, 8);  drain(40);
        bad_start(5'd8, 6'd8);         drain(10);
        bad_start(5'd0, 6'd26);        drain(10);
        bad_start(5'd8, 6'd33);        drain(10);
        bad_start(5'd17, 6'd26);       drain(10);

        do_start(5'd5, 6'd26, 5);      drain(40);
        do_start(5'd16, 6'd26, 16);    drain(40);

        // start at l=5 must be ignored; done still 17 cycles after the first start
        do_start(5'd8, 6'd26, 8);
        repeat (5) @(negedge clk);
        cfg_bpc = 5'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        drain(40);

        // clear at l=3 aborts generation
        do_start(5'd8, 6'd26, -1);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("busy_after_clear", -1, {31'd0, busy}, 32'd0);
        snap(1'b0, 0);
        drain(10);
        repeat (20) @(negedge clk);

        // clear wins over a simultaneous legal start
        do_start(5'd5, 6'd26, 5);      drain(40);
        @(negedge clk);
        clear = 1'b1; cfg_bpc = 5'd8; cfg_limit = 6'd26; start = 1'b1;
        @(negedge clk); clear = 1'b0; start = 1'b0;
        snap(1'b0, 0);
        drain(10);
        repeat (20) @(negedge clk);

        // asynchronous reset in the middle of generation
        do_start(5'd8, 6'd26, -1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("busy_async_reset", -1, {31'd0, busy}, 32'd0);
        snap(1'b0, 0);
        drain(10);
        @(negedge clk); reset = 1'b0;
        do_start(5'd8, 6'd26, 8);      drain(40);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
